hamming_rx_dec: RTL and testbench
=================================

# hamming_rx_dec

Receive-side Hamming(12,8) single-error-correcting decoder for the text link. It sits between the BPSK demodulator and the decryptor and is the decode partner of the transmit-side Hamming encoder. It accepts 12-bit codewords over a valid/ready stream, corrects single-bit errors in a 2-stage pipeline with full backpressure, and emits 8-bit data with per-word error flags and saturating error counters.

## Interface
Parameters:
- CNT_W, 16, width of the error counters

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  codeword present on in_code
- in_ready  out  1  decoder accepts the codeword this cycle
- in_code  in  12  codeword; bit i = Hamming position i+1
- out_valid  out  1  decoded word present
- out_ready  in  1  downstream accepts the word this cycle
- out_data  out  8  corrected data byte
- out_corrected  out  1  single-bit error was corrected in this word
- out_fatal  out  1  uncorrectable syndrome in this word
- clr_counts  in  1  synchronous clear of both counters
- cnt_corrected  out  CNT_W  count of corrected words delivered
- cnt_fatal  out  CNT_W  count of fatal words delivered

## Operation
- Codeword layout by position (1..12):
  - Parity bits p1, p2, p4, p8 at positions 1, 2, 4, 8.
  - Data bits d0..d7 at positions 3, 5, 6, 7, 9, 10, 11, 12.
  - Even parity: pk is the XOR of every position whose index has bit k set.
- Syndrome is the 4-bit value s[k] = XOR of all positions whose index has bit k set (parity bit included).
- Decode rules by syndrome:
  - s = 0: no error; data passed as received; both flags 0.
  - s = 1..12: flip position s, then extract data; out_corrected = 1. A parity-bit-only error (s = 1, 2, 4, 8) is also flagged corrected.
  - s = 13..15: no flip; data extracted raw; out_fatal = 1, out_corrected = 0.
- Stage 1 (S1) registers in_code and computes the syndrome. Stage 2 (S2) applies the correction, extracts data and registers the outputs.
- Counters:
  - Increment on the output handshake (out_valid && out_ready) when the delivered word's corresponding flag is set.
  - Saturate at all-ones.
  - clr_counts forces both counters to 0 on the next edge; clear wins over a simultaneous increment.

## Timing
- Reset values: out_valid = 0, out_data = 0, out_corrected = 0, out_fatal = 0, both counters = 0, both stage-valid registers = 0. in_ready = 1 once reset is released.
- Latency: word accepted at edge N appears on the outputs after edge N+1. Throughput is 1 word/cycle while out_ready is held high.
- Handshake:
  - s2_adv = !out_valid || out_ready.
  - s1_adv = !s1_valid || s2_adv.
  - in_ready = s1_adv (combinational from out_ready; no register in that path).
- Outputs are stable while out_valid && !out_ready. No word is dropped or duplicated under any out_ready pattern.
- When in_valid = 0, a bubble propagates: S2 receives valid = 0 and its data is don't-care. out_data holds its last value.
- Reset asserted mid-stream: both stages are emptied immediately, in-flight words are discarded, and counters are zeroed.

## Structure
- A shared package holds:
  - Position-index constants for the parity and data bits.
  - Syndrome width (4) and codeword width (12).
  - A function for data extraction from a 12-bit word. The transmit-side encoder reuses the same package.
- One sub-module: hamming_syndrome12, purely combinational (12-bit code in, 4-bit syndrome out), instantiated in S1.
- The pipeline control and counters are in the top module.

## Test plan
- Clean word: in_code = 0xA27 (data 0xA5) with out_ready = 1 → out_data = 0xA5 two edges later; both flags 0; counters unchanged.
- Single error: in_code = 0xA07 (position 6 flipped) → out_data = 0xA5, out_corrected = 1, cnt_corrected = 1.
- Fatal: in_code = 0x226 (positions 1 and 12 flipped, s = 13) → out_data = 0x25, out_fatal = 1, cnt_fatal = 1.
- Backpressure:
  - Stream 8 words with out_ready toggling 1,0,0,1,….
  - Required: every word is delivered exactly once, in order.
  - Required: in_ready = 0 exactly when both stages are full and out_ready = 0.
- Counter saturation and clear:
  - Preload via 65540 corrected words → cnt_corrected = 0xFFFF and holds.
  - Then assert clr_counts together with a corrected handshake → counter reads 0.
- Reset mid-stream: assert reset with both stages full → out_valid = 0 the same cycle; no stale word appears after release.

Source files
------------

// File: rtl/hamming_rx_dec_pkg.sv
// ============================================================================
// Package  : hamming_rx_dec_pkg
// Brief    : Hamming(12,8) layout constants and helpers shared by the TX encoder and RX decoder.
// Revision : 1.0
// ============================================================================
`default_nettype none

package hamming_rx_dec_pkg;

  localparam int CODE_W = 12;
  localparam int SYND_W = 4;
  localparam int DATA_W = 8;

  localparam int P1_POS = 1;
  localparam int P2_POS = 2;
  localparam int P4_POS = 4;
  localparam int P8_POS = 8;

  localparam int D0_POS = 3;
  localparam int D1_POS = 5;
  localparam int D2_POS = 6;
  localparam int D3_POS = 7;
  localparam int D4_POS = 9;
  localparam int D5_POS = 10;
  localparam int D6_POS = 11;
  localparam int D7_POS = 12;

  // Bit k of each mask selects every code bit whose 1-based position has bit k set.
  localparam logic [SYND_W-1:0][CODE_W-1:0] SYN_MASK = {
    12'hF80, 12'h878, 12'h666, 12'h555
  };

  typedef enum logic [1:0] {
    SYN_CLEAN = 2'd0,
    SYN_CORR  = 2'd1,
    SYN_FATAL = 2'd2
  } syn_class_e;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              corrected;
    logic              fatal;
  } dec_word_t;

  function automatic logic [DATA_W-1:0] extract_data(input logic [CODE_W-1:0] code);
    return {code[D7_POS-1], code[D6_POS-1], code[D5_POS-1], code[D4_POS-1],
            code[D3_POS-1], code[D2_POS-1], code[D1_POS-1], code[D0_POS-1]};
  endfunction

  function automatic syn_class_e classify(input logic [SYND_W-1:0] syn);
    if (syn == '0) begin
      return SYN_CLEAN;
    end else if (syn <= SYND_W'(CODE_W)) begin
      return SYN_CORR;
    end else begin
      return SYN_FATAL;
    end
  endfunction

endpackage

`default_nettype wire

// File: rtl/hamming_rx_dec_syndrome12.sv
// ============================================================================
// Module   : hamming_syndrome12
// Brief    : Combinational 4-bit syndrome of a 12-bit Hamming codeword.
// Revision : 1.0
// ============================================================================
`default_nettype none

module hamming_syndrome12
  import hamming_rx_dec_pkg::*;
(
  input  logic [CODE_W-1:0] code,
  output logic [SYND_W-1:0] syndrome
);

  for (genvar k = 0; k < SYND_W; k++) begin : g_synd
    assign syndrome[k] = ^(code & SYN_MASK[k]);
  end

endmodule

`default_nettype wire

// File: rtl/hamming_rx_dec.sv
// ============================================================================
// Module   : hamming_rx_dec
// Brief    : 2-stage Hamming(12,8) SEC decoder with valid/ready backpressure
//            and saturating corrected/fatal word counters.
// Revision : 1.0
// ============================================================================
`default_nettype none

module hamming_rx_dec
  import hamming_rx_dec_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CODE_W-1:0] in_code,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_corrected,
  output logic              out_fatal,
  input  logic              clr_counts,
  output logic [CNT_W-1:0]  cnt_corrected,
  output logic [CNT_W-1:0]  cnt_fatal
);

  localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

  logic              w_s2_adv;
  logic              w_s1_adv;
  logic              w_out_hs;
  logic              r_s1_valid;
  logic [CODE_W-1:0] r_s1_code;
  logic [SYND_W-1:0] w_synd;
  logic [CODE_W-1:0] w_flip;
  syn_class_e        w_class;
  dec_word_t         w_dec;

  // in_ready is purely combinational from out_ready so a stall releases in the same cycle.
  assign w_s2_adv = !out_valid || out_ready;
  assign w_s1_adv = !r_s1_valid || w_s2_adv;
  assign in_ready = w_s1_adv;
  assign w_out_hs = out_valid && out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_code  <= '0;
    end else if (w_s1_adv) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_code <= in_code;
      end
    end
  end

  hamming_syndrome12 u_syndrome (
    .code     (r_s1_code),
    .syndrome (w_synd)
  );

  // Syndromes 13..15 match no position, so fatal words pass through unflipped.
  for (genvar i = 0; i < CODE_W; i++) begin : g_flip
    assign w_flip[i] = (w_synd == SYND_W'(i + 1));
  end

  assign w_class = classify(w_synd);

  always_comb begin
    w_dec           = '0;
    w_dec.data      = extract_data(r_s1_code ^ w_flip);
    w_dec.corrected = (w_class == SYN_CORR);
    w_dec.fatal     = (w_class == SYN_FATAL);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid     <= 1'b0;
      out_data      <= '0;
      out_corrected <= 1'b0;
      out_fatal     <= 1'b0;
    end else if (w_s2_adv) begin
      out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        out_data      <= w_dec.data;
        out_corrected <= w_dec.corrected;
        out_fatal     <= w_dec.fatal;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_corrected <= '0;
      cnt_fatal     <= '0;
    end else if (clr_counts) begin
      cnt_corrected <= '0;
      cnt_fatal     <= '0;
    end else begin
      if (w_out_hs && out_corrected && (cnt_corrected != '1)) begin
        cnt_corrected <= cnt_corrected + c_cnt_one;
      end
      if (w_out_hs && out_fatal && (cnt_fatal != '1)) begin
        cnt_fatal <= cnt_fatal + c_cnt_one;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_hamming_rx_dec.sv
// ============================================================================
// Module   : tb_hamming_rx_dec
// Brief    : Self-checking bench for hamming_rx_dec with a position-arithmetic reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_hamming_rx_dec;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] in_code;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_corrected;
  logic        out_fatal;
  logic        clr_counts;
  logic [15:0] cnt_corrected;
  logic [15:0] cnt_fatal;

  always #5 clk = ~clk;

  hamming_rx_dec #(.CNT_W(16)) dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_code       (in_code),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_corrected (out_corrected),
    .out_fatal     (out_fatal),
    .clr_counts    (clr_counts),
    .cnt_corrected (cnt_corrected),
    .cnt_fatal     (cnt_fatal)
  );

  typedef struct {
    logic [11:0] code;
    logic [7:0]  data;
    logic        corr;
    logic        fatal;
  } vec_t;

  typedef struct {
    logic [7:0] data;
    logic       corr;
    logic       fatal;
  } exp_t;

  localparam int NV = 10;

  int          n_chk = 0;
  int          n_err = 0;
  int          n_deliv = 0;
  exp_t        q[$];
  logic [15:0] m_cc = '0;
  logic [15:0] m_cf = '0;
  bit          hold_pend = 1'b0;
  logic [9:0]  held = '0;
  bit          last_acc = 1'b0;
  int          dpos[8] = '{3, 5, 6, 7, 9, 10, 11, 12};
  vec_t        tbl[NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Syndrome as the XOR of the indices of every set position.
  function automatic logic [3:0] syn_of(input logic [11:0] c);
    logic [3:0] s = '0;
    for (int p = 1; p <= 12; p++) if (c[p-1]) s ^= 4'(p);
    return s;
  endfunction

  function automatic logic [11:0] encode(input logic [7:0] d);
    logic [11:0] c = '0;
    logic [3:0]  s;
    for (int i = 0; i < 8; i++) c[dpos[i]-1] = d[i];
    s = syn_of(c);
    for (int k = 0; k < 4; k++) c[(1 << k) - 1] = s[k];
    return c;
  endfunction

  function automatic exp_t model(input logic [11:0] c);
    exp_t e;
    int   s = int'(syn_of(c));
    e.corr  = (s >= 1 && s <= 12);
    e.fatal = (s > 12);
    if (e.corr) c[s-1] = ~c[s-1];
    for (int i = 0; i < 8; i++) e.data[i] = c[dpos[i]-1];
    return e;
  endfunction

  // Mid-cycle scoreboard: the values seen here are exactly what the next edge will act on.
  task automatic monitor();
    exp_t        e;
    logic [15:0] nc;
    logic [15:0] nf;
    last_acc = 1'b0;
    if (reset) begin
      q.delete();
      m_cc = '0;
      m_cf = '0;
      hold_pend = 1'b0;
      return;
    end
    check("cnt_corrected", 32'(cnt_corrected), 32'(m_cc));
    check("cnt_fatal", 32'(cnt_fatal), 32'(m_cf));
    check("in_ready", 32'(in_ready), 32'(!(q.size() == 2 && !out_ready)));
    if (hold_pend)
      check("stall_hold", 32'({out_valid, out_data, out_corrected, out_fatal}), 32'({1'b1, held}));
    hold_pend = out_valid && !out_ready;
    held = {out_data, out_corrected, out_fatal};
    nc = m_cc;
    nf = m_cf;
    if (out_valid && out_ready) begin
      n_deliv++;
      if (q.size() == 0) begin
        check("spurious_word", 32'(out_valid), 32'(0));
      end else begin
        e = q.pop_front();
        check("out_word", 32'({out_data, out_corrected, out_fatal}), 32'({e.data, e.corr, e.fatal}));
        if (e.corr && nc != 16'hFFFF) nc = nc + 16'd1;
        if (e.fatal && nf != 16'hFFFF) nf = nf + 16'd1;
      end
    end
    if (clr_counts) begin
      nc = '0;
      nf = '0;
    end
    m_cc = nc;
    m_cf = nf;
    if (in_valid && in_ready) begin
      q.push_back(model(in_code));
      last_acc = 1'b1;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [11:0] words[8];
    logic [11:0] code;
    int          sent;
    int          d0;
    int          tc;
    int          tf;

    reset = 1'b0; in_valid = 1'b0; in_code = '0; out_ready = 1'b0; clr_counts = 1'b0;
    tbl[0] = '{12'hA27, 8'hA5, 1'b0, 1'b0};
    tbl[1] = '{12'hA07, 8'hA5, 1'b1, 1'b0};
    tbl[2] = '{12'h226, 8'h25, 1'b0, 1'b1};
    tbl[3] = '{12'hA26, 8'hA5, 1'b1, 1'b0};
    tbl[4] = '{12'hA2F, 8'hA5, 1'b1, 1'b0};
    tbl[5] = '{12'h227, 8'hA5, 1'b1, 1'b0};
    tbl[6] = '{12'h223, 8'h24, 1'b0, 1'b1};
    tbl[7] = '{12'h225, 8'h25, 1'b0, 1'b1};
    tbl[8] = '{12'h000, 8'h00, 1'b0, 1'b0};
    tbl[9] = '{12'hFFF, 8'h7F, 1'b1, 1'b0};

    #1 reset = 1'b1;
    #6;
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_out_data", 32'(out_data), 32'(0));
    check("rst_flags", 32'({out_corrected, out_fatal}), 32'(0));
    check("rst_counters", 32'({cnt_corrected, cnt_fatal}), 32'(0));
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'(1));

    tc = 0; tf = 0;
    for (int i = 0; i < NV; i++) begin
      in_valid = 1'b1; in_code = tbl[i].code; out_ready = 1'b1;
      cycle();
      in_valid = 1'b0;
      cycle();
      check($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(1));
      check($sformatf("vec%0d_data", i), 32'(out_data), 32'(tbl[i].data));
      check($sformatf("vec%0d_flags", i), 32'({out_corrected, out_fatal}), 32'({tbl[i].corr, tbl[i].fatal}));
      if (tbl[i].corr) tc++;
      if (tbl[i].fatal) tf++;
      cycle();
      check($sformatf("vec%0d_cnt_corr", i), 32'(cnt_corrected), 32'(tc));
      check($sformatf("vec%0d_cnt_fatal", i), 32'(cnt_fatal), 32'(tf));
    end

    for (int i = 0; i < 8; i++)
      words[i] = encode(8'($urandom)) ^ ((i % 3 == 1) ? 12'(1 << $urandom_range(0, 11)) : 12'h000);
    sent = 0;
    d0 = n_deliv;
    for (int c = 0; c < 200 && !(sent == 8 && n_deliv - d0 == 8); c++) begin
      in_valid  = (sent < 8);
      in_code   = words[(sent < 8) ? sent : 7];
      out_ready = (c % 4 == 0) || (c % 4 == 3);
      cycle();
      if (last_acc) sent++;
    end
    check("bp_sent", 32'(sent), 32'(8));
    check("bp_delivered", 32'(n_deliv - d0), 32'(8));

    for (int c = 0; c < 400; c++) begin
      code = encode(8'($urandom));
      repeat ($urandom_range(0, 2)) code[$urandom_range(0, 11)] ^= 1'b1;
      in_valid   = ($urandom_range(0, 3) != 0);
      in_code    = code;
      out_ready  = ($urandom_range(0, 2) != 0);
      clr_counts = ($urandom_range(0, 29) == 0);
      cycle();
    end
    clr_counts = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) cycle();
    check("rand_drain", 32'(q.size()), 32'(0));

    clr_counts = 1'b1;
    cycle();
    clr_counts = 1'b0;
    in_valid = 1'b1; in_code = 12'hA07; out_ready = 1'b1;
    for (int c = 0; c < 65545; c++) cycle();
    check("sat_reach", 32'(cnt_corrected), 32'(16'hFFFF));
    repeat (3) cycle();
    check("sat_hold", 32'(cnt_corrected), 32'(16'hFFFF));
    clr_counts = 1'b1;
    cycle();
    check("clr_wins", 32'(cnt_corrected), 32'(0));
    clr_counts = 1'b0;
    cycle();
    check("post_clr_inc", 32'(cnt_corrected), 32'(1));

    in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) cycle();
    in_valid = 1'b1; in_code = encode(8'h3C); out_ready = 1'b0;
    cycle();
    in_code = encode(8'hC3);
    cycle();
    in_valid = 1'b0;
    #1;
    check("full_in_ready", 32'(in_ready), 32'(0));
    check("full_out_valid", 32'(out_valid), 32'(1));
    #1 reset = 1'b1;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'(0));
    check("midrst_counters", 32'({cnt_corrected, cnt_fatal}), 32'(0));
    cycle();
    reset = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      cycle();
      check($sformatf("post_rst_no_stale%0d", c), 32'(out_valid), 32'(0));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
